execute_muldiv_unit: RTL
========================

# execute_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the execute stage, directly downstream of the decode/execute pipeline register. It accepts one M-extension operation (funct7 = 0000001, opcode 0110011), selected by the registered funct3 and operand fields. It computes the result iteratively and raises a stall request to the hazard logic while busy. It returns the result with its destination register for the execute/memory register.

## Interface
Parameters: none (XLEN fixed at 32).

- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous active-high reset
- start_i  input  1  launch operation (decode/execute register holds a valid M-type instruction)
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a_i  input  32  rs1 value (forwarded)
- operand_b_i  input  32  rs2 value (forwarded)
- rd_i  input  5  destination register
- flush_i  input  1  abort in-flight operation (branch/jump redirect)
- busy_o  output  1  stall request; high in RUN and FIX
- done_o  output  1  one-cycle pulse, result_o/rd_o valid
- result_o  output  32  result, held until next FIX update
- rd_o  output  5  destination register of the completed operation

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- The start edge is the edge at which start_i is sampled. start_i is honoured only in IDLE or DONE. At the start edge, latch funct3, operands, and rd.
  - Div-by-zero (funct3[2]=1, b=0) goes to FIX.
  - Any multiply with MULDIV_FAST_MUL_EN defined goes to FIX.
  - All other operations go to RUN with count=0.
- Signed handling:
  - Signed operands: DIV, REM, MUL, MULH both; MULHSU a only.
  - Signed operands are replaced by their magnitude. Result sign = sign_a XOR sign_b for quotient/product; sign_a for remainder.
- RUN, multiply: shift-add, one multiplier bit per cycle into a 64-bit unsigned product.
- RUN, divide: restoring, one quotient bit per cycle; 32-bit remainder, 32-bit quotient.
- RUN exits to FIX when count=31, i.e. after 32 iterations.
- FIX: apply sign negation, then select the result:
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Write result_o and rd_o, then go to DONE.
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = dividend.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0. The magnitude algorithm produces this naturally and must not be special-cased wrongly.
- DONE: done_o=1 for one cycle, then go to IDLE unless start_i re-launches.
- flush_i in RUN, FIX or DONE goes to IDLE next edge: no result_o write, no done_o. flush_i in IDLE is ignored, and flush_i has priority over start_i.
- rst_i has priority over everything.

## Timing
- Reset values: state IDLE, busy_o 0, done_o 0, result_o 0, rd_o 0, count 0.
- Iterative op, start at edge 0: RUN during edges 1..32, FIX at edge 33, done_o high in the cycle after edge 33.
- Short path (div-by-zero, or fast multiply): FIX at edge 1, done_o high in the cycle after edge 1.
- busy_o is combinational from state (RUN or FIX). It is low in DONE, so the pipeline advances in the done cycle.
- Back-to-back: start_i in a DONE cycle launches the next operation at that edge, with no idle bubble.
- Operand inputs may change freely after the start edge because they are latched.
- Reset asserted mid-operation: state returns to IDLE at the next edge and no done_o is produced.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - Multiplies use a single-cycle 33x33 signed combinational product computed in FIX from the latched operands.
  - Multiply latency is 2 (same as div-by-zero).
  - The shift-add path is not compiled.
- Undefined: multiplies use the 32-iteration path with latency 34.
- Divide behaviour is identical in both builds.

## Test plan
- MUL 7 × 0xFFFFFFFD -> result_o 0xFFFFFFEB, rd_o as given; done_o pulse exactly 34 cycles after start edge (2 with MULDIV_FAST_MUL_EN), busy_o high throughout.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF; MULH 0x80000000 × 0x80000000 -> 0x40000000.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
- DIVU 100 / 0 -> 0xFFFFFFFF and REMU 100 / 0 -> 100; done_o 2 cycles after start, busy_o high for 1 cycle.
- DIVU 1000/7 launched, flush_i at cycle 10 -> busy_o low next cycle, no done_o, result_o unchanged. Then REMU 1000/7 -> 6, correct latency.
- rst_i at cycle 15 of a DIV -> all outputs 0 next cycle. start_i in DONE cycle of a MUL -> second op completes 34 cycles later with no bubble.

Source files
------------

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit
//
// Iterative RV32M multiply/divide unit for the execute stage. One operation
// is launched from the decode/execute register. The result is produced after
// 32 shift-add or restoring-divide iterations, followed by a sign-fix cycle.
// busy_o stalls the pipeline while the operation is in flight.
//
// Optional feature: define MULDIV_FAST_MUL_EN to replace the shift-add
// multiplier with a single-cycle 33x33 signed product, which is evaluated in
// the FIX state. With this option multiply latency is 2. Divide behaviour is
// the same in both builds.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      launch an operation (honoured in IDLE or DONE)
//   funct3_i     000 MUL 001 MULH 010 MULHSU 011 MULHU
//                100 DIV 101 DIVU 110 REM 111 REMU
//   operand_a_i  rs1 value
//   operand_b_i  rs2 value
//   rd_i         destination register
//   flush_i      abort the in-flight operation (ignored in IDLE)
//   busy_o       stall request, high in RUN and FIX
//   done_o       one-cycle completion pulse
//   result_o     result, held until the next completion
//   rd_o         destination register of the completed operation

module execute_muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [2:0]  op;
  logic [4:0]  rd_lat;
  logic [31:0] opnd;      // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [63:0] prod;      // mul: {acc, multiplier}; div: {remainder, quotient}
  logic        neg_q;     // negate product / quotient
  logic        neg_r;     // negate remainder
  logic        dz;        // divide by zero
  logic [31:0] result_reg;
  logic [4:0]  rd_out_reg;

  // ---------------------------------------------------------------------
  // Operand conditioning at the start edge
  // ---------------------------------------------------------------------
  logic        is_div_in, sa_in, sb_in, neg_a_in, neg_b_in, dz_in, launch, short_path;
  logic [31:0] a_abs, b_abs;

  assign is_div_in = funct3_i[2];
  // Signed a: MUL, MULH, MULHSU, DIV, REM. Signed b: MUL, MULH, DIV, REM.
  assign sa_in     = is_div_in ? ~funct3_i[0] : (~funct3_i[1] | ~funct3_i[0]);
  assign sb_in     = is_div_in ? ~funct3_i[0] : ~funct3_i[1];
  assign neg_a_in  = sa_in & operand_a_i[31];
  assign neg_b_in  = sb_in & operand_b_i[31];
  assign a_abs     = neg_a_in ? -operand_a_i : operand_a_i;
  assign b_abs     = neg_b_in ? -operand_b_i : operand_b_i;
  assign dz_in     = is_div_in & (operand_b_i == 32'd0);

  // In DONE a flush wins over a re-launch; in IDLE the flush is ignored.
  assign launch = start_i & ((state == IDLE) | ((state == DONE) & ~flush_i));

`ifdef MULDIV_FAST_MUL_EN
  assign short_path = dz_in | ~is_div_in;
`else
  assign short_path = dz_in;
`endif

  // ---------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------
  // Restoring divide: shift {rem, quot} left by one, then subtract the divisor
  // if it fits. rem < divisor < 2^32, so the difference always fits in 32 bits.
  logic [32:0] div_shift;
  logic        div_fits;
  logic [31:0] div_diff;
  logic [63:0] div_step;

  assign div_shift = {prod[63:32], prod[31]};
  assign div_fits  = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift[31:0] - opnd;
  assign div_step  = div_fits ? {div_diff, prod[30:0], 1'b1}
                              : {div_shift[31:0], prod[30:0], 1'b0};

  logic [63:0] run_step;
`ifdef MULDIV_FAST_MUL_EN
  assign run_step = div_step;
`else
  // Shift-add: add the multiplicand into the upper half when the multiplier
  // LSB is set, then shift the whole 65-bit {carry, acc, multiplier} right.
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  assign mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
  assign mul_step = {mul_sum, prod[31:1]};
  assign run_step = op[2] ? div_step : mul_step;
`endif

  // ---------------------------------------------------------------------
  // FIX: sign application and result selection
  // ---------------------------------------------------------------------
  logic [63:0] mul_full;
  logic [31:0] quot_fix, rem_fix, fix_result;

`ifdef MULDIV_FAST_MUL_EN
  logic [31:0]        a_raw, b_raw;
  logic signed [32:0] fast_a, fast_b;
  assign fast_a   = $signed({(~op[1] | ~op[0]) & a_raw[31], a_raw});
  assign fast_b   = $signed({~op[1] & b_raw[31], b_raw});
  assign mul_full = 64'(fast_a * fast_b);
`else
  assign mul_full = neg_q ? -prod : prod;
`endif

  // Divide by zero returns all ones for the quotient regardless of signs.
  assign quot_fix = dz ? 32'hFFFF_FFFF : (neg_q ? -prod[31:0] : prod[31:0]);
  assign rem_fix  = neg_r ? -prod[63:32] : prod[63:32];

  always_comb begin
    fix_result = 32'd0;
    if (op[2]) begin
      fix_result = op[1] ? rem_fix : quot_fix;
    end else begin
      fix_result = (op[1:0] == 2'b00) ? mul_full[31:0] : mul_full[63:32];
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_next = short_path ? FIX : RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (flush_i)               state_next = IDLE;
        else if (count == 5'd31)   state_next = FIX;
      end
      FIX: begin
        busy_o = 1'b1;
        if (flush_i) state_next = IDLE;
        else         state_next = DONE;
      end
      DONE: begin
        done_o = ~flush_i;
        if (launch) state_next = short_path ? FIX : RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      count      <= 5'd0;
      op         <= 3'd0;
      rd_lat     <= 5'd0;
      opnd       <= 32'd0;
      prod       <= 64'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      dz         <= 1'b0;
      result_reg <= 32'd0;
      rd_out_reg <= 5'd0;
`ifdef MULDIV_FAST_MUL_EN
      a_raw      <= 32'd0;
      b_raw      <= 32'd0;
`endif
    end else begin
      state <= state_next;
      if (launch) begin
        op     <= funct3_i;
        rd_lat <= rd_i;
        count  <= 5'd0;
        neg_q  <= neg_a_in ^ neg_b_in;
        neg_r  <= neg_a_in;
        dz     <= dz_in;
        opnd   <= is_div_in ? b_abs : a_abs;
        // Divide by zero skips RUN: preload remainder = |dividend|.
        if (dz_in)          prod <= {a_abs, 32'hFFFF_FFFF};
        else if (is_div_in) prod <= {32'd0, a_abs};
        else                prod <= {32'd0, b_abs};
`ifdef MULDIV_FAST_MUL_EN
        a_raw <= operand_a_i;
        b_raw <= operand_b_i;
`endif
      end else if ((state == RUN) && !flush_i) begin
        prod  <= run_step;
        count <= count + 5'd1;
      end
      if ((state == FIX) && !flush_i) begin
        result_reg <= fix_result;
        rd_out_reg <= rd_lat;
      end
    end
  end

  assign result_o = result_reg;
  assign rd_o     = rd_out_reg;

endmodule
